reg_writeback: RTL and testbench

Write-side master for the CPU register file: collects results from the ALU and the load unit and drives the register file write port (`wa`, `wda`, `reg_wr`), one write per cycle. ALU results have priority. Load results queue in a small FIFO. A 32-entry busy scoreboard tracks destinations that have been issued but not yet written, for the decode stage to stall on. Sits between the execute/memory stages and `reg_file`.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/reg_writeback.sv | 128 ++++++++++++
 tb/tb_reg_writeback.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback block.
package wb_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DEFAULT_XLEN = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_result_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback results; storage is not reset, only pointers and count.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_result_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write master: ALU-priority arbitration, load FIFO, x0 filter, busy scoreboard.
// Optional load bypass of the empty FIFO is enabled by defining WB_LD_BYPASS_EN.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = DEFAULT_XLEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_W-1:0]     alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [REG_ADDR_W-1:0]     ld_rd,
  input  logic [XLEN-1:0]           ld_data,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_W-1:0]     issue_rd,
  output logic [REG_ADDR_W-1:0]     wa,
  output logic [XLEN-1:0]           wda,
  output logic                      reg_wr,
  output logic [NUM_REGS-1:0]       busy,
  output logic [$clog2(DEPTH):0]    ld_count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } res_t;

  res_t                    ld_res;
  res_t                    head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    ld_acc;
  logic                    byp;
  logic                    push;
  logic                    pop;
  logic                    sel_vld_p0;
  logic [REG_ADDR_W-1:0]   sel_rd_p0;
  logic [XLEN-1:0]         sel_data_p0;
  logic [NUM_REGS-1:0]     busy_nxt;

  assign ld_res   = '{rd: ld_rd, data: ld_data};
  assign ld_ready = !fifo_full;
  assign ld_acc   = ld_valid && ld_ready;

`ifdef WB_LD_BYPASS_EN
  // A load may skip the FIFO only when nothing older is queued and the port is free.
  assign byp = ld_acc && fifo_empty && !alu_valid;
`else
  assign byp = 1'b0;
`endif

  assign push = ld_acc && !byp;
  assign pop  = !alu_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (ld_res),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ld_count)
  );

  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_rd_p0   = '0;
    sel_data_p0 = '0;
    if (alu_valid) begin
      sel_vld_p0  = 1'b1;
      sel_rd_p0   = alu_rd;
      sel_data_p0 = alu_data;
    end else if (!fifo_empty) begin
      sel_vld_p0  = 1'b1;
      sel_rd_p0   = head.rd;
      sel_data_p0 = head.data;
    end else if (byp) begin
      sel_vld_p0  = 1'b1;
      sel_rd_p0   = ld_rd;
      sel_data_p0 = ld_data;
    end
  end

  // Stage boundary p0 -> register-file write port; rd 0 results are consumed but never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr <= 1'b0;
      wa     <= '0;
      wda    <= '0;
    end else begin
      reg_wr <= sel_vld_p0 && (sel_rd_p0 != '0);
      if (sel_vld_p0) begin
        wa  <= sel_rd_p0;
        wda <= sel_data_p0;
      end
    end
  end

  // Set is applied after clear so a same-edge re-issue keeps the bit busy.
  always_comb begin
    busy_nxt = busy;
    if (reg_wr) begin
      busy_nxt[wa] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected writes are queued at issue, a monitor checks the port.
module tb_reg_writeback;

`ifdef WB_LD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  wa;
  logic [31:0] wda;
  logic        reg_wr;
  logic [31:0] busy;
  logic [2:0]  ld_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(4), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wa          (wa),
    .wda         (wda),
    .reg_wr      (reg_wr),
    .busy        (busy),
    .ld_count    (ld_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every visible write must match the oldest expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_wr === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_write: got wa=%0d wda=0x%0h, want no write", wa, wda);
        end else begin
          e = q.pop_front();
          chk("wr_addr", {27'd0, wa}, {27'd0, e.rd});
          chk("wr_data", wda, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ld_idx;
    bit  acc;
    bit  seen;

    reset = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; issue_valid = 1'b0; issue_rd = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reg_wr",   {31'd0, reg_wr}, 32'd0);
    chk("rst_wa",       {27'd0, wa}, 32'd0);
    chk("rst_wda",      wda, 32'd0);
    chk("rst_busy",     busy, 32'd0);
    chk("rst_ld_count", {29'd0, ld_count}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    reset = 1'b1;
    step();

    // Single ALU write, then an x0 ALU result that must be swallowed.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    push_exp(5'd5, 32'h1234);
    step();
    alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("x0_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("x0_busy",   busy, 32'd0);
    step();

    // ALU holds the port for 6 cycles while loads 1..6 are offered.
    ld_idx = 1;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + i;
      push_exp(5'(10 + i), 32'h100 + i);
      ld_valid = 1'b1; ld_rd = 5'(ld_idx); ld_data = 32'h200 + ld_idx;
      acc = ld_ready;
      step();
      if (acc) ld_idx++;
    end
    chk("fill_accepts",  ld_idx - 1, 32'd4);
    chk("fill_ld_count", {29'd0, ld_count}, 32'd4);
    chk("fill_ld_ready", {31'd0, ld_ready}, 32'd0);
    alu_valid = 1'b0;
    for (int k = 1; k <= 6; k++) push_exp(5'(k), 32'h200 + k);
    for (int c = 0; c < 30 && ld_idx <= 6; c++) begin
      ld_valid = 1'b1; ld_rd = 5'(ld_idx); ld_data = 32'h200 + ld_idx;
      acc = ld_ready;
      step();
      if (acc) ld_idx++;
    end
    ld_valid = 1'b0;
    chk("late_loads_accepted", ld_idx, 32'd7);
    for (int c = 0; c < 30; c++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    step();
    chk("drain_queue",    q.size(), 32'd0);
    chk("drain_ld_count", {29'd0, ld_count}, 32'd0);

    // Scoreboard: issue rd 7, retire it with a load, watch busy[7].
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("busy7_set", busy, 32'h80);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA5;
    push_exp(5'd7, 32'hA5);
    step();
    ld_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (reg_wr === 1'b1) begin seen = 1'b1; break; end
      chk("busy7_pending", {31'd0, busy[7]}, 32'd1);
    end
    chk("busy7_write_seen", {31'd0, seen}, 32'd1);
    chk("busy7_during_wr",  {31'd0, busy[7]}, 32'd1);
    step();
    chk("busy7_cleared", {31'd0, busy[7]}, 32'd0);

    // Re-issue of rd 7 on the very edge that clears it.
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h5A;
    push_exp(5'd7, 32'h5A);
    step();
    ld_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (reg_wr === 1'b1) begin seen = 1'b1; break; end
    end
    chk("reissue_write_seen", {31'd0, seen}, 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("busy7_set_wins", {31'd0, busy[7]}, 32'd1);
    repeat (2) step();

    // Load latency from idle: 1 cycle with bypass, 2 without.
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h55;
    push_exp(5'd9, 32'h55);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("byp_first_reg_wr",  {31'd0, reg_wr}, {31'd0, BYP});
    chk("byp_first_count",   {29'd0, ld_count}, BYP ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("byp_second_reg_wr", {31'd0, reg_wr}, {31'd0, !BYP});
    repeat (2) step();

    // Mid-operation reset with 3 loads queued behind the ALU.
    issue_valid = 1'b1; issue_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'h300 + i;
      push_exp(5'(20 + i), 32'h300 + i);
      ld_valid = 1'b1; ld_rd = 5'(11 + i); ld_data = 32'h400 + i;
      step();
      issue_valid = 1'b0;
    end
    ld_valid = 1'b0;
    alu_rd = 5'd23; alu_data = 32'h303;
    push_exp(5'd23, 32'h303);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ld_count", {29'd0, ld_count}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_reg_wr",   {31'd0, reg_wr}, 32'd0);
    chk("mid_rst_ld_count", {29'd0, ld_count}, 32'd0);
    chk("mid_rst_busy",     busy, 32'd0);
    chk("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);
    chk("final_ld_count",    {29'd0, ld_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
